// File: rtl/inst_encoder_pkg.sv
// Shared opcodes, instruction formats, immediate range limits and FIFO entry
// layout for the RV32I instruction encoder.
package inst_encoder_pkg;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_SYS, FMT_BAD
    } fmt_e;

    // Signed byte-immediate limits; B and J additionally need imm[0] == 0.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } fifo_entry_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_ARITH:                        return FMT_R;
            OP_ARITH_IMM, OP_LOAD, OP_JALR:  return FMT_I;
            OP_STORE:                        return FMT_S;
            OP_BRANCH:                       return FMT_B;
            OP_JAL:                          return FMT_J;
            OP_ECALL:                        return FMT_SYS;
            default:                         return FMT_BAD;
        endcase
    endfunction

    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// Output FIFO of encoded words: DEPTH entries of {inst, addr, err}.
// Head reads as all-zero while empty.
module inst_enc_fifo
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  fifo_entry_t wr_data,
    input  logic        pop,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction assembler: encodes fields into a word, range-checks the
// immediate, tags it with its byte address and queues it for the imem writer.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        err_seen
);
    enc_req_t    req;
    fmt_e        fmt;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic [31:0] addr;
    logic        push, full, empty;
    fifo_entry_t wr_entry, head;

    assign req = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                   funct3: funct3, funct7: funct7, imm: imm};
    assign fmt = fmt_of(req.opcode);

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R: enc_inst = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I: begin
                enc_err  = !imm_in_range(req.imm, IMM12_MIN, IMM12_MAX);
                enc_inst = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            end
            FMT_S: begin
                enc_err  = !imm_in_range(req.imm, IMM12_MIN, IMM12_MAX);
                enc_inst = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            end
            FMT_B: begin
                enc_err  = !imm_in_range(req.imm, IMM_B_MIN, IMM_B_MAX) || req.imm[0];
                enc_inst = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                            req.imm[4:1], req.imm[11], req.opcode};
            end
            FMT_J: begin
                enc_err  = !imm_in_range(req.imm, IMM_J_MIN, IMM_J_MAX) || req.imm[0];
                enc_inst = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                            req.rd, req.opcode};
            end
            FMT_SYS: enc_inst = ECALL_WORD;
            default: enc_err  = 1'b1;
        endcase
    end

    // Error entries carry a zero word and do not consume an address.
    assign wr_entry = '{inst: enc_err ? 32'h0 : enc_inst, addr: addr, err: enc_err};
    assign in_ready = !full;
    assign push     = in_valid && in_ready && !restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= BASE_ADDR;
            err_seen <= 1'b0;
        end else if (restart) begin
            addr     <= BASE_ADDR;
            err_seen <= 1'b0;
        end else if (push) begin
            if (enc_err) err_seen <= 1'b1;
            else         addr     <= addr + 32'd4;
        end
    end

    inst_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (restart),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (out_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = !empty;
    assign out_inst  = head.inst;
    assign out_addr  = head.addr;
    assign out_err   = head.err;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector and soak bench for inst_encoder.
module tb_inst_encoder;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, in_ready, out_valid, out_ready, out_err, err_seen;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm, out_inst, out_addr;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_seen(err_seen)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    localparam int NV = 19;
    vec_t tbl[NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string nm, logic [6:0] op, logic [4:0] d, logic [4:0] s1,
                                logic [4:0] s2, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] im, logic [31:0] ei, logic [31:0] ea, logic ee);
        vec_t v;
        v.name = nm; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3; v.f7 = f7;
        v.imm = im; v.exp_inst = ei; v.exp_addr = ea; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(vec_t v);
        int t = 0;
        @(negedge clk);
        opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk({v.name, "_push_timeout"}, {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_check(string nm, logic [31:0] ei, logic [31:0] ea, logic ee);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk({nm, "_inst"}, out_inst, ei);
        chk({nm, "_addr"}, out_addr, ea);
        chk({nm, "_err"}, {31'h0, out_err}, {31'h0, ee});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        exp_t        q[$];
        exp_t        e;
        logic [31:0] model_addr;
        int          k;
        logic        acc, pop;

        tbl[0]  = mk("addi_m1",   7'b0010011, 1, 0, 0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF00093, 32'h00, 1'b0);
        tbl[1]  = mk("sw_8",      7'b0100011, 0, 1, 2, 3'd2, 7'h00, 32'd8,         32'h0020A423, 32'h04, 1'b0);
        tbl[2]  = mk("beq_m4",    7'b1100011, 0, 0, 0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE000EE3, 32'h08, 1'b0);
        tbl[3]  = mk("jal_2048",  7'b1101111, 1, 0, 0, 3'd0, 7'h00, 32'd2048,      32'h001000EF, 32'h0C, 1'b0);
        tbl[4]  = mk("ecall",     7'b1110011, 5, 7, 9, 3'd3, 7'h55, 32'd123,       32'h00000073, 32'h10, 1'b0);
        tbl[5]  = mk("addi_2048", 7'b0010011, 1, 0, 0, 3'd0, 7'h00, 32'd2048,      32'h0,        32'h14, 1'b1);
        tbl[6]  = mk("beq_odd",   7'b1100011, 0, 0, 0, 3'd0, 7'h00, 32'd3,         32'h0,        32'h14, 1'b1);
        tbl[7]  = mk("addi_2047", 7'b0010011, 1, 0, 0, 3'd0, 7'h00, 32'd2047,      32'h7FF00093, 32'h14, 1'b0);
        tbl[8]  = mk("add",       7'b0110011, 3, 1, 2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h002081B3, 32'h18, 1'b0);
        tbl[9]  = mk("sub",       7'b0110011, 3, 1, 2, 3'd0, 7'h20, 32'd0,         32'h402081B3, 32'h1C, 1'b0);
        tbl[10] = mk("lw_m2048",  7'b0000011, 5, 2, 0, 3'd2, 7'h00, 32'hFFFF_F800, 32'h80012283, 32'h20, 1'b0);
        tbl[11] = mk("bad_op",    7'b1111111, 1, 1, 1, 3'd0, 7'h00, 32'd0,         32'h0,        32'h24, 1'b1);
        tbl[12] = mk("jal_odd",   7'b1101111, 1, 0, 0, 3'd0, 7'h00, 32'd1,         32'h0,        32'h24, 1'b1);
        tbl[13] = mk("bne_4094",  7'b1100011, 0, 1, 2, 3'd1, 7'h00, 32'd4094,      32'h7E209FE3, 32'h24, 1'b0);
        tbl[14] = mk("beq_4096",  7'b1100011, 0, 0, 0, 3'd0, 7'h00, 32'd4096,      32'h0,        32'h28, 1'b1);
        tbl[15] = mk("jal_min",   7'b1101111, 0, 0, 0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000006F, 32'h28, 1'b0);
        tbl[16] = mk("jal_2p20",  7'b1101111, 0, 0, 0, 3'd0, 7'h00, 32'h0010_0000, 32'h0,        32'h2C, 1'b1);
        tbl[17] = mk("sw_m2049",  7'b0100011, 0, 1, 2, 3'd2, 7'h00, 32'hFFFF_F7FF, 32'h0,        32'h2C, 1'b1);
        tbl[18] = mk("jalr",      7'b1100111, 1, 5, 0, 3'd0, 7'h00, 32'd0,         32'h000280E7, 32'h2C, 1'b0);

        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_out_err", {31'h0, out_err}, 32'h0);
        chk("rst_err_seen", {31'h0, err_seen}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;

        // Directed table: one word through at a time.
        for (int i = 0; i < NV; i++) begin
            push(tbl[i]);
            pop_check(tbl[i].name, tbl[i].exp_inst, tbl[i].exp_addr, tbl[i].exp_err);
        end
        chk("tbl_err_seen", {31'h0, err_seen}, 32'h1);
        chk("tbl_empty_valid", {31'h0, out_valid}, 32'h0);
        chk("tbl_empty_inst", out_inst, 32'h0);
        chk("tbl_empty_addr", out_addr, 32'h0);

        // Backpressure: fill, stall, then drain while the third push waits.
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        chk("rs_err_seen", {31'h0, err_seen}, 32'h0);
        push(tbl[0]);
        push(tbl[1]);
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_hold_inst0", out_inst, 32'hFFF00093);
        @(negedge clk);
        chk("bp_hold_inst1", out_inst, 32'hFFF00093);
        chk("bp_hold_addr1", out_addr, 32'h0);
        fork
            push(tbl[2]);
        join_none
        pop_check("bp0", 32'hFFF00093, 32'h0, 1'b0);
        pop_check("bp1", 32'h0020A423, 32'h4, 1'b0);
        pop_check("bp2", 32'hFE000EE3, 32'h8, 1'b0);
        wait fork;
        @(negedge clk);
        chk("bp_drained", {31'h0, out_valid}, 32'h0);

        // Random ready/valid soak against a queue model.
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        model_addr = 32'h0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            k = $urandom_range(NV - 1);
            opcode = tbl[k].op; rd = tbl[k].rd; rs1 = tbl[k].rs1; rs2 = tbl[k].rs2;
            funct3 = tbl[k].f3; funct7 = tbl[k].f7; imm = tbl[k].imm;
            in_valid  = (c < 360) ? ($urandom_range(3) != 0) : 1'b0;
            out_ready = (c < 360) ? ($urandom_range(2) != 0) : 1'b1;
            chk("soak_in_ready", {31'h0, in_ready}, {31'h0, (q.size() < DEPTH)});
            chk("soak_out_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop && q.size() != 0) begin
                e = q.pop_front();
                chk("soak_inst", out_inst, e.inst);
                chk("soak_addr", out_addr, e.addr);
                chk("soak_err", {31'h0, out_err}, {31'h0, e.err});
            end
            if (acc) begin
                e.inst = tbl[k].exp_inst;
                e.addr = model_addr;
                e.err  = tbl[k].exp_err;
                q.push_back(e);
                if (!tbl[k].exp_err) model_addr = model_addr + 32'd4;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("soak_final_empty", {31'h0, out_valid}, 32'h0);
        chk("soak_model_empty", q.size(), 32'h0);

        // Async reset drops buffered entries immediately.
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        push(tbl[5]);
        push(tbl[0]);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_out_inst", out_inst, 32'h0);
        chk("arst_err_seen", {31'h0, err_seen}, 32'h0);
        chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk); reset = 1'b0;
        push(tbl[7]);
        pop_check("post_rst", 32'h7FF00093, 32'h0, 1'b0);

        // Restart wins over a same-cycle push.
        push(tbl[5]);
        chk("pre_rs_err_seen", {31'h0, err_seen}, 32'h1);
        push(tbl[0]);
        @(negedge clk);
        restart = 1'b1; in_valid = 1'b1;
        opcode = tbl[9].op; rd = tbl[9].rd; rs1 = tbl[9].rs1; rs2 = tbl[9].rs2;
        funct3 = tbl[9].f3; funct7 = tbl[9].f7; imm = tbl[9].imm;
        @(negedge clk);
        restart = 1'b0; in_valid = 1'b0;
        chk("rs_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rs_err_clear", {31'h0, err_seen}, 32'h0);
        push(tbl[8]);
        pop_check("post_rs", 32'h002081B3, 32'h0, 1'b0);
        @(negedge clk);
        chk("post_rs_empty", {31'h0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
